// File: rtl/exu_bjp_resolver_if.sv
// Commit/flush bus between the commit stage, the branch resolver and the IFU.
// The resolver takes the slave modport; the commit stage / IFU side takes master.
interface exu_bjp_resolver_if #(
  parameter int PC_W = 32,
  parameter int XLEN = 32
);
  // commit slot
  logic            cmt_i_valid;
  logic            cmt_i_ready;
  logic            cmt_i_bjp;
  logic            cmt_i_jalr;
  logic            cmt_i_bjp_prdt;
  logic            cmt_i_bjp_rslv;
  logic [PC_W-1:0] cmt_i_pc;
  logic [XLEN-1:0] cmt_i_imm;
  logic [XLEN-1:0] cmt_i_rs1;
  // flush request toward the IFU
  logic            flush_o_valid;
  logic            flush_o_ready;
  logic [PC_W-1:0] flush_o_pc;

  modport master (
    output cmt_i_valid, cmt_i_bjp, cmt_i_jalr, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
           cmt_i_pc, cmt_i_imm, cmt_i_rs1, flush_o_ready,
    input  cmt_i_ready, flush_o_valid, flush_o_pc
  );

  modport slave (
    input  cmt_i_valid, cmt_i_bjp, cmt_i_jalr, cmt_i_bjp_prdt, cmt_i_bjp_rslv,
           cmt_i_pc, cmt_i_imm, cmt_i_rs1, flush_o_ready,
    output cmt_i_ready, flush_o_valid, flush_o_pc
  );
endinterface

// File: rtl/exu_bjp_resolver.sv
// Commit-stage branch/jump resolver. Compares each committed branch/jump with
// the fetch prediction, issues a flush with the corrected PC on a mispredict,
// stalls commit until the IFU takes the flush, and keeps saturating counters.
// Immediate and rs1 are truncated to PC_W bits, so XLEN >= PC_W is expected.
module exu_bjp_resolver #(
  parameter int PC_W  = 32,
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  exu_bjp_resolver_if.slave bus,
  output logic [CNT_W-1:0] stat_bjp_cnt,
  output logic [CNT_W-1:0] stat_mis_cnt
);

  typedef enum logic {IDLE = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state_reg, state_next;
  logic             flush_valid_reg, flush_valid_next;
  logic [PC_W-1:0]  flush_pc_reg, flush_pc_next;
  logic [CNT_W-1:0] bjp_cnt_reg, bjp_cnt_next;
  logic [CNT_W-1:0] mis_cnt_reg, mis_cnt_next;

  logic             accept;
  logic             bjp_accept;
  logic             mispredict;
  logic [PC_W-1:0]  imm_pc;
  logic [PC_W-1:0]  rs1_pc;
  logic [PC_W-1:0]  target;

  assign bus.cmt_i_ready   = (state_reg == IDLE);
  assign bus.flush_o_valid = flush_valid_reg;
  assign bus.flush_o_pc    = flush_pc_reg;
  assign stat_bjp_cnt      = bjp_cnt_reg;
  assign stat_mis_cnt      = mis_cnt_reg;

  assign imm_pc = bus.cmt_i_imm[PC_W-1:0];
  assign rs1_pc = bus.cmt_i_rs1[PC_W-1:0];

  // Decode the accepted commit: jalr has no target predictor, so it always mispredicts.
  always_comb begin
    accept     = bus.cmt_i_valid & (state_reg == IDLE);
    bjp_accept = accept & bus.cmt_i_bjp;
    mispredict = bjp_accept &
                 (bus.cmt_i_jalr | (bus.cmt_i_bjp_prdt != bus.cmt_i_bjp_rslv));
    if (bus.cmt_i_jalr)
      target = (rs1_pc + imm_pc) & {{(PC_W-1){1'b1}}, 1'b0};
    else if (bus.cmt_i_bjp_rslv)
      target = bus.cmt_i_pc + imm_pc;
    else
      target = bus.cmt_i_pc + PC_W'(4);
  end

  // Next-state, flush request and saturating counter updates.
  always_comb begin
    state_next       = state_reg;
    flush_valid_next = flush_valid_reg;
    flush_pc_next    = flush_pc_reg;
    bjp_cnt_next     = bjp_cnt_reg;
    mis_cnt_next     = mis_cnt_reg;

    case (state_reg)
      IDLE: begin
        if (mispredict) begin
          state_next       = FLUSH;
          flush_valid_next = 1'b1;
          flush_pc_next    = target;
        end
      end
      FLUSH: begin
        if (bus.flush_o_ready) begin
          state_next       = IDLE;
          flush_valid_next = 1'b0;
        end
      end
      default: begin
        state_next       = IDLE;
        flush_valid_next = 1'b0;
      end
    endcase

    if (bjp_accept && (bjp_cnt_reg != {CNT_W{1'b1}}))
      bjp_cnt_next = bjp_cnt_reg + CNT_W'(1);
    if (mispredict && (mis_cnt_reg != {CNT_W{1'b1}}))
      mis_cnt_next = mis_cnt_reg + CNT_W'(1);
  end

  // State register; reset drops any pending flush and clears the counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg       <= IDLE;
      flush_valid_reg <= 1'b0;
      flush_pc_reg    <= '0;
      bjp_cnt_reg     <= '0;
      mis_cnt_reg     <= '0;
    end else begin
      state_reg       <= state_next;
      flush_valid_reg <= flush_valid_next;
      flush_pc_reg    <= flush_pc_next;
      bjp_cnt_reg     <= bjp_cnt_next;
      mis_cnt_reg     <= mis_cnt_next;
    end
  end

endmodule

// File: tb/tb_exu_bjp_resolver.sv
// Directed bench for exu_bjp_resolver. Two instances share one stimulus: a
// 16-bit-counter instance and a 2-bit-counter instance for saturation.
module tb_exu_bjp_resolver;

  logic        clk;
  logic        rst;
  logic        valid, bjp, jalr, prdt, rslv, fready;
  logic [31:0] pc, imm, rs1;

  logic [15:0] bjp_cnt, mis_cnt;
  logic [1:0]  sat_bjp_cnt, sat_mis_cnt;

  int n_checks;
  int n_pass;

  exu_bjp_resolver_if #(.PC_W(32), .XLEN(32)) bus ();
  exu_bjp_resolver_if #(.PC_W(32), .XLEN(32)) bus_sat ();

  assign bus.cmt_i_valid    = valid;
  assign bus.cmt_i_bjp      = bjp;
  assign bus.cmt_i_jalr     = jalr;
  assign bus.cmt_i_bjp_prdt = prdt;
  assign bus.cmt_i_bjp_rslv = rslv;
  assign bus.cmt_i_pc       = pc;
  assign bus.cmt_i_imm      = imm;
  assign bus.cmt_i_rs1      = rs1;
  assign bus.flush_o_ready  = fready;

  assign bus_sat.cmt_i_valid    = valid;
  assign bus_sat.cmt_i_bjp      = bjp;
  assign bus_sat.cmt_i_jalr     = jalr;
  assign bus_sat.cmt_i_bjp_prdt = prdt;
  assign bus_sat.cmt_i_bjp_rslv = rslv;
  assign bus_sat.cmt_i_pc       = pc;
  assign bus_sat.cmt_i_imm      = imm;
  assign bus_sat.cmt_i_rs1      = rs1;
  assign bus_sat.flush_o_ready  = fready;

  exu_bjp_resolver #(.PC_W(32), .XLEN(32), .CNT_W(16)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .stat_bjp_cnt (bjp_cnt),
    .stat_mis_cnt (mis_cnt)
  );

  exu_bjp_resolver #(.PC_W(32), .XLEN(32), .CNT_W(2)) u_dut_sat (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus_sat),
    .stat_bjp_cnt (sat_bjp_cnt),
    .stat_mis_cnt (sat_mis_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // advance one rising edge and settle
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // present one commit for exactly one edge (DUT must be IDLE)
  task automatic commit(input logic b, input logic j, input logic p, input logic r,
                        input logic [31:0] cpc, input logic [31:0] cimm, input logic [31:0] crs1);
    valid = 1'b1; bjp = b; jalr = j; prdt = p; rslv = r;
    pc = cpc; imm = cimm; rs1 = crs1;
    step();
    valid = 1'b0;
    $display("commit bjp=%0d jalr=%0d prdt=%0d rslv=%0d pc=%h imm=%h rs1=%h -> fv=%0d fpc=%h",
             b, j, p, r, cpc, cimm, crs1, bus.flush_o_valid, bus.flush_o_pc);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    rst = 1'b0; fready = 1'b0;
    valid = 1'b1; bjp = 1'b1; jalr = 1'b1; prdt = 1'b0; rslv = 1'b1;
    pc = 32'h8000_0010; imm = 32'h20; rs1 = 32'h0;

    // 1: reset held 2 cycles with a valid mispredicting commit on the bus
    step(); step();
    check("rst_fvalid", bus.flush_o_valid, 1'b0);
    check("rst_fpc", bus.flush_o_pc, 32'h0);
    check("rst_bjp_cnt", bjp_cnt, 16'd0);
    check("rst_mis_cnt", mis_cnt, 16'd0);
    valid = 1'b0; rst = 1'b1;
    step();
    check("rst_ready", bus.cmt_i_ready, 1'b1);
    check("rst_fvalid_after", bus.flush_o_valid, 1'b0);

    // 2: beq predicted not-taken, resolved taken
    commit(1, 0, 0, 1, 32'h8000_0010, 32'h20, 32'h0);
    check("t2_fvalid", bus.flush_o_valid, 1'b1);
    check("t2_fpc", bus.flush_o_pc, 32'h8000_0030);
    check("t2_ready", bus.cmt_i_ready, 1'b0);
    fready = 1'b1;
    step();
    fready = 1'b0;
    check("t2_fvalid_drop", bus.flush_o_valid, 1'b0);
    check("t2_ready_back", bus.cmt_i_ready, 1'b1);

    // 3: predicted taken, resolved not-taken; IFU stalls 3 cycles while commit presses
    commit(1, 0, 1, 0, 32'h8000_0010, 32'h20, 32'h0);
    check("t3_fpc", bus.flush_o_pc, 32'h8000_0014);
    valid = 1'b1; bjp = 1'b1; jalr = 1'b1; rs1 = 32'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t3_hold_fvalid", bus.flush_o_valid, 1'b1);
      check("t3_hold_fpc", bus.flush_o_pc, 32'h8000_0014);
      check("t3_hold_ready", bus.cmt_i_ready, 1'b0);
    end
    valid = 1'b0; fready = 1'b1;
    step();
    fready = 1'b0;
    check("t3_fvalid_drop", bus.flush_o_valid, 1'b0);
    check("t3_ready_back", bus.cmt_i_ready, 1'b1);
    check("t3_fpc_retained", bus.flush_o_pc, 32'h8000_0014);
    check("t3_bjp_cnt", bjp_cnt, 16'd2);
    check("t3_mis_cnt", mis_cnt, 16'd2);

    // 4: jalr with IFU ready early -> one-cycle flush dwell
    fready = 1'b1;
    commit(1, 1, 1, 0, 32'h8000_0100, 32'hFFFF_FFFC, 32'h8000_1001);
    check("t4_fvalid", bus.flush_o_valid, 1'b1);
    check("t4_fpc", bus.flush_o_pc, 32'h8000_0FFC);
    step();
    fready = 1'b0;
    check("t4_min_dwell", bus.flush_o_valid, 1'b0);
    check("t4_ready_back", bus.cmt_i_ready, 1'b1);

    // 4b: back-to-back correct predictions with one non-bjp (mismatched bits, no effect)
    valid = 1'b1; jalr = 1'b0; pc = 32'h8000_0200; imm = 32'h40;
    for (int i = 0; i < 11; i++) begin
      bjp  = (i != 5);
      prdt = i[0];
      rslv = (i == 5) ? ~i[0] : i[0];
      step();
      $display("stream %0d bjp=%0d prdt=%0d rslv=%0d -> fv=%0d", i, bjp, prdt, rslv, bus.flush_o_valid);
      check("t4_stream_fvalid", bus.flush_o_valid, 1'b0);
      check("t4_stream_ready", bus.cmt_i_ready, 1'b1);
    end
    valid = 1'b0;
    check("t4_bjp_cnt", bjp_cnt, 16'd13);
    check("t4_mis_cnt", mis_cnt, 16'd3);

    // 5: not-taken mispredict at top of address space wraps to 0
    commit(1, 0, 1, 0, 32'hFFFF_FFFC, 32'h10, 32'h0);
    check("t5_fvalid", bus.flush_o_valid, 1'b1);
    check("t5_fpc_wrap", bus.flush_o_pc, 32'h0);
    fready = 1'b1; step(); fready = 1'b0;
    commit(1, 0, 0, 1, 32'h0000_0100, 32'hFFFF_FFF8, 32'h0);
    check("t5_fpc_back", bus.flush_o_pc, 32'h0000_00F8);
    fready = 1'b1; step(); fready = 1'b0;
    commit(1, 1, 1, 1, 32'h0000_0300, 32'h11, 32'h0000_2000);
    check("t5_fpc_jalr", bus.flush_o_pc, 32'h0000_2010);
    fready = 1'b1; step(); fready = 1'b0;
    check("t5_bjp_cnt", bjp_cnt, 16'd16);
    check("t5_mis_cnt", mis_cnt, 16'd6);
    check("t5_sat_mis_cnt", sat_mis_cnt, 2'd3);
    check("t5_sat_bjp_cnt", sat_bjp_cnt, 2'd3);

    // 6: reset collides with the flush handshake
    commit(1, 0, 0, 1, 32'h8000_0010, 32'h20, 32'h0);
    check("t6_fvalid_pre", bus.flush_o_valid, 1'b1);
    rst = 1'b0; fready = 1'b1;
    step();
    rst = 1'b1; fready = 1'b0;
    check("t6_fvalid", bus.flush_o_valid, 1'b0);
    check("t6_ready", bus.cmt_i_ready, 1'b1);
    check("t6_fpc", bus.flush_o_pc, 32'h0);
    check("t6_bjp_cnt", bjp_cnt, 16'd0);
    check("t6_mis_cnt", mis_cnt, 16'd0);
    check("t6_sat_mis_cnt", sat_mis_cnt, 2'd0);
    commit(1, 0, 1, 1, 32'h8000_0400, 32'h8, 32'h0);
    check("t6_post_fvalid", bus.flush_o_valid, 1'b0);
    check("t6_post_bjp_cnt", bjp_cnt, 16'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
